// File: rtl/btn_led_ctrl_pkg.sv
// ============================================================================
// btn_led_ctrl_pkg : shared FSM states, mode type and LED colour codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package btn_led_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG      = 3'd2,
        ST_RST_PULSE = 3'd3,
        ST_WAIT_REL  = 3'd4
    } state_t;

    typedef logic [1:0] mode_t;

    // LED drive codes ordered {r, g, b}; 0 lights the LED.
    localparam logic [2:0] LED_RED   = 3'b011;
    localparam logic [2:0] LED_GREEN = 3'b101;
    localparam logic [2:0] LED_BLUE  = 3'b110;
    localparam logic [2:0] LED_WHITE = 3'b000;
    localparam logic [2:0] LED_OFF   = 3'b111;

    function automatic logic [2:0] led_for_mode(input mode_t m);
        logic [2:0] code;
        code = LED_RED;
        case (m)
            2'd0:    code = LED_RED;
            2'd1:    code = LED_GREEN;
            2'd2:    code = LED_BLUE;
            default: code = LED_WHITE;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_led_ctrl_debounce.sv
// ============================================================================
// btn_debounce : 2-flop synchroniser followed by a stable-level debouncer
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic clk48,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any cycle where the input agrees with the accepted level restarts the run.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/btn_led_ctrl.sv
// ============================================================================
// btn_led_ctrl : button-driven RGB colour selector with long-press board reset
// Option macro BTN_LONG_PRESS_RESET_EN enables the sys_rst_n pulse on long press.
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_led_ctrl
    import btn_led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 480000,
    parameter int LONG_PRESS_CYCLES  = 96000000,
    parameter int RESET_PULSE_CYCLES = 4800
) (
    input  logic       clk48,
    input  logic       rst_n,
    input  logic       usr_btn_b,
    output logic       usr_btn_a,
    output logic       rgb_led0_r,
    output logic       rgb_led0_g,
    output logic       rgb_led0_b,
    output logic       sys_rst_n,
    output logic [1:0] mode
);

    localparam int            HW        = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    state_t        state;
    state_t        state_nxt;
    mode_t         mode_nxt;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;
    logic          btn_level;

    assign usr_btn_a = 1'b1;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk48(clk48),
        .rst_n(rst_n),
        .raw  (usr_btn_b),
        .level(btn_level)
    );

`ifdef BTN_LONG_PRESS_RESET_EN
    localparam int            PW         = $clog2(RESET_PULSE_CYCLES + 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);

    logic [PW-1:0] pulse;
    logic [PW-1:0] pulse_nxt;
`else
    // Pulse length has no effect without the board-reset option.
    if (RESET_PULSE_CYCLES < 0) begin : g_pulse_unused
    end
`endif

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        hold_nxt  = hold;
`ifdef BTN_LONG_PRESS_RESET_EN
        pulse_nxt = pulse;
`endif
        case (state)
            ST_IDLE: begin
                if (btn_level) begin
                    state_nxt = ST_PRESSED;
                    hold_nxt  = '0;
                end
            end
            ST_PRESSED: begin
                if (!btn_level) begin
                    state_nxt = ST_IDLE;
                    mode_nxt  = mode + 2'd1;
                end else begin
                    if (hold != HOLD_MAX) begin
                        hold_nxt = hold + HOLD_ONE;
                    end
                    if (hold == HOLD_LAST) begin
                        state_nxt = ST_LONG;
                    end
                end
            end
            ST_LONG: begin
`ifdef BTN_LONG_PRESS_RESET_EN
                state_nxt = ST_RST_PULSE;
                pulse_nxt = '0;
`else
                state_nxt = ST_WAIT_REL;
`endif
            end
`ifdef BTN_LONG_PRESS_RESET_EN
            ST_RST_PULSE: begin
                pulse_nxt = pulse + PULSE_ONE;
                if (pulse == PULSE_LAST) begin
                    state_nxt = ST_WAIT_REL;
                end
            end
`endif
            ST_WAIT_REL: begin
                if (!btn_level) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            mode  <= 2'd0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            mode  <= mode_nxt;
            hold  <= hold_nxt;
        end
    end

    // LEDs follow the registered mode/state, so a colour change lands one cycle after mode.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            {rgb_led0_r, rgb_led0_g, rgb_led0_b} <= LED_RED;
        end else if (state == ST_LONG || state == ST_RST_PULSE || state == ST_WAIT_REL) begin
            {rgb_led0_r, rgb_led0_g, rgb_led0_b} <= LED_OFF;
        end else begin
            {rgb_led0_r, rgb_led0_g, rgb_led0_b} <= led_for_mode(mode);
        end
    end

`ifdef BTN_LONG_PRESS_RESET_EN
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            pulse     <= '0;
            sys_rst_n <= 1'b1;
        end else begin
            pulse     <= pulse_nxt;
            sys_rst_n <= (state != ST_RST_PULSE);
        end
    end
`else
    assign sys_rst_n = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_led_ctrl.sv
// ============================================================================
// tb_btn_led_ctrl : directed bench with a timestamp-based behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_btn_led_ctrl;

    localparam int D = 4;
    localparam int L = 20;
    localparam int P = 3;
`ifdef BTN_LONG_PRESS_RESET_EN
    localparam int PM       = P;
    localparam bit PULSE_EN = 1'b1;
`else
    localparam int PM       = 0;
    localparam bit PULSE_EN = 1'b0;
`endif

    logic       clk48     = 1'b0;
    logic       rst_n     = 1'b0;
    logic       usr_btn_b = 1'b0;
    logic       usr_btn_a;
    logic       rgb_led0_r;
    logic       rgb_led0_g;
    logic       rgb_led0_b;
    logic       sys_rst_n;
    logic [1:0] mode;

    btn_led_ctrl #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .RESET_PULSE_CYCLES(P)
    ) dut (
        .clk48     (clk48),
        .rst_n     (rst_n),
        .usr_btn_b (usr_btn_b),
        .usr_btn_a (usr_btn_a),
        .rgb_led0_r(rgb_led0_r),
        .rgb_led0_g(rgb_led0_g),
        .rgb_led0_b(rgb_led0_b),
        .sys_rst_n (sys_rst_n),
        .mode      (mode)
    );

    always #5 clk48 = ~clk48;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] exp_leds(input int m, input bit off);
        logic [2:0] c;
        if (off)         c = 3'b111;
        else if (m == 0) c = 3'b011;
        else if (m == 1) c = 3'b101;
        else if (m == 2) c = 3'b110;
        else             c = 3'b000;
        return c;
    endfunction

    // Model: raw delayed two edges, level flips after D consecutive opposing samples,
    // press classified by how long after entering the pressed phase the release is seen.
    logic       r1, r2, m_level, rawn, all_diff, e_srst;
    logic [2:0] e_led;
    logic       hist[$];
    int         m_mode = 0;
    bit         pressing = 1'b0;
    bit         longp = 1'b0;
    int         s = 0;

    initial begin
        r1 = 1'b0; r2 = 1'b0; m_level = 1'b0;
    end

    always @(posedge clk48) begin
        rawn = usr_btn_b;
        cyc++;
        #1;
        if (!rst_n) begin
            r1 = 1'b0; r2 = 1'b0; m_level = 1'b0;
            hist.delete();
            m_mode = 0; pressing = 1'b0; longp = 1'b0;
            e_led  = 3'b011;
            e_srst = 1'b1;
        end else begin
            e_led  = exp_leds(m_mode, longp);
            e_srst = !(longp && PULSE_EN && (cyc - 1 >= s + L + 1) && (cyc - 1 <= s + L + P));
            if (longp) begin
                if (!m_level && cyc >= s + L + 2 + PM) longp = 1'b0;
            end else if (pressing) begin
                if (!m_level) begin
                    pressing = 1'b0;
                    m_mode   = (m_mode + 1) % 4;
                end else if (cyc == s + L) begin
                    pressing = 1'b0;
                    longp    = 1'b1;
                end
            end else if (m_level) begin
                pressing = 1'b1;
                s        = cyc;
            end
            hist.push_back(r2);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
                if (all_diff) m_level = !m_level;
            end
            r2 = r1;
            r1 = rawn;
            if (!sys_rst_n) low_cnt++;
        end
        check("mode", mode, m_mode);
        check("leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, e_led);
        check("sys_rst_n", sys_rst_n, e_srst);
        check("btn_a", usr_btn_a, 1'b1);
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk48);
    endtask

    task automatic short_press(input int hi, input int lo);
        usr_btn_b = 1'b1;
        wait_neg(hi);
        usr_btn_b = 1'b0;
        wait_neg(lo);
    endtask

    int         exp_mode_tbl[3] = '{2, 3, 0};
    logic [2:0] exp_led_tbl[3]  = '{3'b110, 3'b000, 3'b011};
    int         w;

    initial begin
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(10);
        check("rst_mode", mode, 0);
        check("rst_leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, 3'b011);
        check("rst_srst", sys_rst_n, 1);

        // Debounced level must rise on the 6th edge after a clean press.
        usr_btn_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk48);
            #2;
            if (k == 5) check("deb_early", dut.u_debounce.level, 0);
            if (k == 6) check("deb_rise", dut.u_debounce.level, 1);
        end
        wait_neg(4);
        usr_btn_b = 1'b0;
        wait_neg(15);
        check("press1_mode", mode, 1);
        check("press1_leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, 3'b101);

        short_press(3, 10);
        check("glitch_level", dut.u_debounce.level, 0);
        check("glitch_mode", mode, 1);

        for (int i = 0; i < 3; i++) begin
            short_press(8, 12);
            check("seq_mode", mode, exp_mode_tbl[i]);
            check("seq_leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, exp_led_tbl[i]);
        end

        low_cnt = 0;
        short_press(40, 15);
        check("long_low_cycles", low_cnt, PM);
        check("long_mode", mode, 0);
        check("long_leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, 3'b011);

        // Reset asserted while the long-press indication is active.
        short_press(8, 12);
        usr_btn_b = 1'b1;
        w = 0;
        while (w < 60 && (PULSE_EN ? (sys_rst_n !== 1'b0)
                                   : ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b111))) begin
            @(negedge clk48);
            w++;
        end
        check("wait_long_event", (w < 60), 1);
        rst_n = 1'b0;
        #1;
        check("arst_srst", sys_rst_n, 1);
        check("arst_mode", mode, 0);
        check("arst_leds", {rgb_led0_r, rgb_led0_g, rgb_led0_b}, 3'b011);
        check("arst_state", dut.state, btn_led_ctrl_pkg::ST_IDLE);
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(10);
        usr_btn_b = 1'b0;
        wait_neg(15);
        check("held_redetect_mode", mode, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/btn_led_ctrl.md
BTN_LED_CTRL -- requirements
Module: btn_led_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 480000, consecutive stable cycles required to accept a button level change (10 ms at 48 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 96000000, debounced-hold cycles that classify a press as long (2 s).
REQ-003 SHALL have parameter RESET_PULSE_CYCLES, default 4800, length of the board-reset pulse in cycles.
REQ-004 SHALL have port clk48  input  1  48 MHz system clock, the only clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port usr_btn_b  input  1  raw button sense; high = pressed; asynchronous to clk48.
REQ-007 SHALL have port usr_btn_a  output  1  button high-side drive; constant 1.
REQ-008 SHALL have ports rgb_led0_r, rgb_led0_g, rgb_led0_b  output  1 each  active-low LED drives.
REQ-009 SHALL have port sys_rst_n  output  1  active-low board-reset request.
REQ-010 SHALL have port mode  output  2  current colour index.

Function
REQ-011 SHALL pass usr_btn_b through a 2-flop synchroniser; both flops reset to 0.
REQ-012 SHALL update the debounced level only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match clears the counter.
REQ-013 SHALL raise the debounced level exactly 2+DEBOUNCE_CYCLES cycles after a clean usr_btn_b rising edge.
REQ-014 SHALL run FSM states IDLE, PRESSED, LONG, RST_PULSE, WAIT_REL.
REQ-015 IDLE -> PRESSED on debounced rise; hold counter cleared.
REQ-016 PRESSED: hold counter increments per cycle; debounced fall before LONG_PRESS_CYCLES -> IDLE and mode increments; reaching LONG_PRESS_CYCLES -> LONG.
REQ-017 LONG -> RST_PULSE on the next cycle; mode unchanged.
REQ-018 RST_PULSE: sys_rst_n low for exactly RESET_PULSE_CYCLES cycles, then -> WAIT_REL.
REQ-019 WAIT_REL -> IDLE on debounced low; no mode change on that release.
REQ-020 mode SHALL wrap 3 -> 0 (2-bit modulo).
REQ-021 LED map (active-low drive): mode 0 red, 1 green, 2 blue, 3 all three on (white).
REQ-022 In LONG, RST_PULSE and WAIT_REL all LEDs SHALL be off (drives = 1) as long-press indication.
REQ-023 Outputs SHALL be registered; LED change visible 1 cycle after the mode update.
REQ-024 Hold counter SHALL saturate; no wrap while held.

Reset
REQ-025 On rst_n low, asynchronously: FSM = IDLE, mode = 0, counters = 0, debounced = 0, sys_rst_n = 1, LEDs = red on (r=0, g=1, b=1).
REQ-026 Reset deassertion mid-press SHALL restart debounce; a held button is re-detected as a new press.
REQ-027 sys_rst_n SHALL never be driven low by the block's own reset input.

Configuration
REQ-028 Macro BTN_LONG_PRESS_RESET_EN defined: behaviour as REQ-017/018.
REQ-029 Macro undefined: LONG -> WAIT_REL directly, RST_PULSE state and pulse counter removed, sys_rst_n tied 1; LED-off indication retained.

Structure
REQ-030 Package btn_led_ctrl_pkg SHALL hold the FSM state enum, 2-bit mode type and LED colour constants.
REQ-031 Synchroniser and debounce SHALL form sub-module btn_debounce (params DEBOUNCE_CYCLES; ports clk48, rst_n, raw, level).
REQ-032 Counter widths SHALL be $clog2(param+1).

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, RESET_PULSE_CYCLES=3)
REQ-033 Reset release, no press -> mode=0, r/g/b=0/1/1, sys_rst_n=1 indefinitely.
REQ-034 Clean press 10 cycles then release -> debounced rise at cycle 6; mode 0->1 after release debounce; r/g/b=1/0/1.
REQ-035 Glitch high 3 cycles -> debounced stays 0, mode unchanged.
REQ-036 Four short presses -> mode sequence 1,2,3,0; white then red.
REQ-037 Hold 40 cycles (macro on) -> sys_rst_n low exactly 3 cycles, LEDs off until release, mode unchanged; macro off -> sys_rst_n stays 1.
REQ-038 rst_n asserted during RST_PULSE -> sys_rst_n=1 immediately, mode=0, FSM IDLE.
